// File: rtl/aes_arb_pkg.sv
// Shared types and byte-map helpers for the AES encrypt-core arbiter.
// State layout is column-major: state[r][c] holds vector byte 4*c+r.
package aes_arb_pkg;

    typedef logic [3:0][3:0][7:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    function automatic aes_state_t vec_to_state(input logic [127:0] vec);
        aes_state_t st;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                st[r][c] = vec[127-8*(4*c+r) -: 8];
            end
        end
        return st;
    endfunction

    function automatic logic [127:0] state_to_vec(input aes_state_t st);
        logic [127:0] vec;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                vec[127-8*(4*c+r) -: 8] = st[r][c];
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin pick: scan req_i from ptr_i upward with wrap,
// first set bit wins. Produces a one-hot grant and the winning index.
module aes_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    localparam int PW = ID_W + 1;

    always_comb begin
        logic [PW-1:0] pos;
        logic          found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr and offset are both below NUM_REQ, so one subtract wraps
            pos = {1'b0, ptr_i} + PW'(i);
            if (pos >= PW'(NUM_REQ)) begin
                pos = pos - PW'(NUM_REQ);
            end
            if (!found && req_i[pos[ID_W-1:0]]) begin
                found                = 1'b1;
                gnt_o[pos[ID_W-1:0]] = 1'b1;
                idx_o                = pos[ID_W-1:0];
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/aes_en_arbiter.sv
// Shares one aes_en_core between NUM_REQ requesters, one job in flight.
// Optional watchdog with rsp_err_o is enabled by defining AES_ARB_TIMEOUT_EN.
module aes_en_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int NO_ROWS        = 4,
    parameter int NO_COLS        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      aes_clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_vld_i,
    output logic [NUM_REQ-1:0]        req_rdy_o,
    input  logic [NUM_REQ-1:0][127:0] req_plain_text_i,
    input  logic [NUM_REQ-1:0][127:0] req_cipher_key_i,
    output logic                      rsp_vld_o,
    input  logic                      rsp_rdy_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [127:0]              rsp_cipher_text_o,
`ifdef AES_ARB_TIMEOUT_EN
    output logic                      rsp_err_o,
`endif
    output logic                      core_en_o,
    output logic                      core_encrypt_mode_en_o,
    output aes_state_t                core_plain_text_o,
    output aes_state_t                core_cipher_key_o,
    input  logic                      core_cipher_text_rdy_i,
    input  aes_state_t                core_cipher_text_i
);

    localparam int STATE_BITS = NO_ROWS * NO_COLS * 8;

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [STATE_BITS-1:0]  pt_q, pt_d;
    logic [STATE_BITS-1:0]  key_q, key_d;
    logic [STATE_BITS-1:0]  res_q, res_d;
    logic                   core_en_q, core_en_d;
    // Low for the first cycle after reset so no accept pulse leaks out of reset
    logic                   arm_q;

    logic [NUM_REQ-1:0]     gnt;
    logic [ID_W-1:0]        gnt_idx;
    logic                   gnt_any;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   err_q, err_d;
`endif

    aes_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_i   (req_vld_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        pt_d      = pt_q;
        key_d     = key_q;
        res_d     = res_q;
        req_rdy_o = '0;
`ifdef AES_ARB_TIMEOUT_EN
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (arm_q && gnt_any) begin
                    req_rdy_o = gnt;
                    id_d      = gnt_idx;
                    pt_d      = req_plain_text_i[gnt_idx];
                    key_d     = req_cipher_key_i[gnt_idx];
`ifdef AES_ARB_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                    state_d   = LOAD;
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                if (core_cipher_text_rdy_i) begin
                    res_d   = state_to_vec(core_cipher_text_i);
                    state_d = RESP;
                end
`ifdef AES_ARB_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_rdy_i) begin
                    rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Core is enabled exactly while the job sits in LOAD/RUN
        core_en_d = (state_d == LOAD) || (state_d == RUN);
    end

`ifdef AES_ARB_TIMEOUT_EN
    always_comb begin
        wd_d = wd_q;
        if (state_d == LOAD) begin
            wd_d = '0;
        end else if (state_q == RUN) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge aes_clk or negedge resetn) begin
        if (!resetn) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign rsp_err_o = err_q;
`endif

    always_ff @(posedge aes_clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            pt_q      <= '0;
            key_q     <= '0;
            res_q     <= '0;
            core_en_q <= 1'b0;
            arm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            pt_q      <= pt_d;
            key_q     <= key_d;
            res_q     <= res_d;
            core_en_q <= core_en_d;
            arm_q     <= 1'b1;
        end
    end

    assign rsp_vld_o              = (state_q == RESP);
    assign rsp_id_o               = id_q;
    assign rsp_cipher_text_o      = res_q;
    assign core_en_o              = core_en_q;
    assign core_encrypt_mode_en_o = core_en_q;
    assign core_plain_text_o      = vec_to_state(pt_q);
    assign core_cipher_key_o      = vec_to_state(key_q);

endmodule

// File: tb/tb_aes_en_arbiter.sv
// Directed bench for aes_en_arbiter with a behavioural core stub.
// Define AES_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_aes_en_arbiter;

    localparam int NR = 4;
    localparam int IW = 2;
`ifdef AES_ARB_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 255;
`endif

    typedef logic [3:0][3:0][7:0] st_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic                 aes_clk = 1'b0;
    logic                 resetn  = 1'b0;
    logic [NR-1:0]        req_vld_i;
    logic [NR-1:0]        req_rdy_o;
    logic [NR-1:0][127:0] req_pt, req_key;
    logic                 rsp_vld_o, rsp_rdy_i;
    logic [IW-1:0]        rsp_id_o;
    logic [127:0]         rsp_cipher_text_o;
`ifdef AES_ARB_TIMEOUT_EN
    logic                 rsp_err_o;
`endif
    logic                 core_en_o, core_encrypt_mode_en_o;
    st_t                  core_plain_text_o, core_cipher_key_o;
    logic                 stub_rdy;
    st_t                  stub_ct;
    logic                 stub_dead = 1'b0;
    logic [1:0]           stub_cnt;

    int checks = 0;
    int fails  = 0;
    int pulses [NR];
    int multi_gnt = 0;

    always #5 aes_clk = ~aes_clk;

    aes_en_arbiter #(
        .NUM_REQ(NR), .ID_W(IW), .NO_ROWS(4), .NO_COLS(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .aes_clk                (aes_clk),
        .resetn                 (resetn),
        .req_vld_i              (req_vld_i),
        .req_rdy_o              (req_rdy_o),
        .req_plain_text_i       (req_pt),
        .req_cipher_key_i       (req_key),
        .rsp_vld_o              (rsp_vld_o),
        .rsp_rdy_i              (rsp_rdy_i),
        .rsp_id_o               (rsp_id_o),
        .rsp_cipher_text_o      (rsp_cipher_text_o),
`ifdef AES_ARB_TIMEOUT_EN
        .rsp_err_o              (rsp_err_o),
`endif
        .core_en_o              (core_en_o),
        .core_encrypt_mode_en_o (core_encrypt_mode_en_o),
        .core_plain_text_o      (core_plain_text_o),
        .core_cipher_key_o      (core_cipher_key_o),
        .core_cipher_text_rdy_i (stub_rdy),
        .core_cipher_text_i     (stub_ct)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Byte k of the vector lands in row k%4, column k/4
    function automatic st_t v2s(input logic [127:0] v);
        st_t s;
        for (int k = 0; k < 16; k++) s[k%4][k/4] = v[127-8*k -: 8];
        return s;
    endfunction

    function automatic logic [127:0] s2v(input st_t s);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[127-8*k -: 8] = s[k%4][k/4];
        return v;
    endfunction

    // Stand-in cipher: the FIPS-197 vector is exact, anything else is a keyed mix
    function automatic logic [127:0] model(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return pt ^ {key[63:0], key[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // Core stub: rdy one cycle after the fourth enabled cycle
    always @(posedge aes_clk or negedge resetn) begin
        if (!resetn) begin
            stub_cnt <= 2'd0;
            stub_rdy <= 1'b0;
            stub_ct  <= '0;
        end else begin
            stub_rdy <= 1'b0;
            if (core_en_o && !stub_dead) begin
                if (stub_cnt == 2'd3) begin
                    stub_rdy <= 1'b1;
                    stub_ct  <= v2s(model(s2v(core_plain_text_o), s2v(core_cipher_key_o)));
                    stub_cnt <= 2'd0;
                end else begin
                    stub_cnt <= stub_cnt + 2'd1;
                end
            end else begin
                stub_cnt <= 2'd0;
            end
        end
    end

    always @(negedge aes_clk) begin
        if (!$onehot0(req_rdy_o)) multi_gnt++;
        for (int i = 0; i < NR; i++) if (req_rdy_o[i]) pulses[i]++;
    end

    task automatic edge1();
        @(posedge aes_clk);
        #1;
    endtask

    task automatic wait_accept(output int who);
        who = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge aes_clk);
            if (|req_rdy_o) begin
                for (int i = 0; i < NR; i++) if (req_rdy_o[i]) who = i;
                break;
            end
        end
        if (who < 0) chk("accept_wait_expired", 128'(0), 128'(1));
    endtask

    task automatic wait_rsp();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge aes_clk);
            if (rsp_vld_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("rsp_wait_expired", 128'(0), 128'(1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},  128'(req_rdy_o), 128'(0));
        chk({tag, "_vld"},  128'(rsp_vld_o), 128'(0));
        chk({tag, "_id"},   128'(rsp_id_o), 128'(0));
        chk({tag, "_ct"},   rsp_cipher_text_o, 128'(0));
        chk({tag, "_en"},   128'(core_en_o), 128'(0));
        chk({tag, "_mode"}, 128'(core_encrypt_mode_en_o), 128'(0));
        chk({tag, "_cpt"},  128'(core_plain_text_o), 128'(0));
        chk({tag, "_ckey"}, 128'(core_cipher_key_o), 128'(0));
    endtask

    initial begin
        int who;
        logic [127:0] exp;
        for (int i = 0; i < NR; i++) begin
            pulses[i]  = 0;
            req_pt[i]  = {32'(i + 1), 32'hA5A50000, 32'(i * 7), 32'hDEADBEEF};
            req_key[i] = {32'hC0DE0000 | 32'(i), 64'h0123456789ABCDEF, 32'(i + 100)};
        end
        rsp_rdy_i = 1'b1;
        req_vld_i = '0;

        // Reset state, with a request already pending
        req_vld_i[1] = 1'b1;
        repeat (3) @(negedge aes_clk);
        chk_all_zero("reset");
        req_vld_i = '0;
        resetn    = 1'b1;
        edge1();

        // Single FIPS-197 job from requester 0
        req_pt[0]    = FIPS_PT;
        req_key[0]   = FIPS_KEY;
        req_vld_i[0] = 1'b1;
        wait_accept(who);
        chk("single_who", 128'(who), 128'(0));
        edge1();
        req_vld_i[0] = 1'b0;
        @(negedge aes_clk);
        chk("load_en",   128'(core_en_o), 128'(1));
        chk("load_mode", 128'(core_encrypt_mode_en_o), 128'(1));
        chk("load_pt",   128'(core_plain_text_o), 128'(v2s(FIPS_PT)));
        chk("load_key",  128'(core_cipher_key_o), 128'(v2s(FIPS_KEY)));
        wait_rsp();
        chk("single_id", 128'(rsp_id_o), 128'(0));
        chk("single_ct", rsp_cipher_text_o, FIPS_CT);
`ifdef AES_ARB_TIMEOUT_EN
        chk("single_err", 128'(rsp_err_o), 128'(0));
`endif
        repeat (3) @(negedge aes_clk);
        chk("single_pulses", 128'(pulses[0]), 128'(1));

        // Pointer wrap: job for 3, then 0 and 1 together -> 0 then 1
        edge1();
        req_vld_i[3] = 1'b1;
        wait_accept(who);
        chk("wrap_who3", 128'(who), 128'(3));
        edge1();
        req_vld_i[3] = 1'b0;
        wait_rsp();
        chk("wrap_id3", 128'(rsp_id_o), 128'(3));
        chk("wrap_ct3", rsp_cipher_text_o, model(req_pt[3], req_key[3]));
        edge1();
        req_vld_i[0] = 1'b1;
        req_vld_i[1] = 1'b1;
        wait_accept(who);
        chk("wrap_first", 128'(who), 128'(0));
        edge1();
        req_vld_i[0] = 1'b0;
        wait_rsp();
        chk("wrap_id0", 128'(rsp_id_o), 128'(0));
        wait_accept(who);
        chk("wrap_second", 128'(who), 128'(1));
        edge1();
        req_vld_i[1] = 1'b0;
        wait_rsp();
        chk("wrap_id1", 128'(rsp_id_o), 128'(1));
        chk("wrap_ct1", rsp_cipher_text_o, model(req_pt[1], req_key[1]));

        // Reset in RUN: everything clears at once, job for 2 is dropped
        edge1();
        req_vld_i[2] = 1'b1;
        wait_accept(who);
        chk("rst_who", 128'(who), 128'(2));
        edge1();
        req_vld_i[2] = 1'b0;
        repeat (3) @(negedge aes_clk);
        chk("rst_run_en", 128'(core_en_o), 128'(1));
        #2 resetn = 1'b0;
        #1 chk_all_zero("rst_async");
        repeat (2) @(posedge aes_clk);
        @(negedge aes_clk);
        resetn = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge aes_clk);
            chk("rst_no_replay_vld", 128'(rsp_vld_o), 128'(0));
            chk("rst_no_replay_en",  128'(core_en_o), 128'(0));
        end
        chk("rst_pulses2", 128'(pulses[2]), 128'(1));

        // Round robin, all held valid; pointer restarts at 0 after reset
        edge1();
        req_vld_i = '1;
        for (int k = 0; k < 8; k++) begin
            wait_accept(who);
            chk($sformatf("rr_who%0d", k), 128'(who), 128'(k % NR));
            if (k == 7) begin
                edge1();
                req_vld_i = '0;
            end
            wait_rsp();
            if (who >= 0) begin
                chk($sformatf("rr_id%0d", k), 128'(rsp_id_o), 128'(who));
                chk($sformatf("rr_ct%0d", k), rsp_cipher_text_o, model(req_pt[who], req_key[who]));
            end
        end

        // Back-pressure: result held, no accept, core idle
        edge1();
        rsp_rdy_i    = 1'b0;
        req_vld_i[0] = 1'b1;
        req_vld_i[1] = 1'b1;
        wait_accept(who);
        chk("bp_who", 128'(who), 128'(0));
        edge1();
        req_vld_i[0] = 1'b0;
        wait_rsp();
        exp = model(req_pt[0], req_key[0]);
        for (int n = 0; n < 20; n++) begin
            @(negedge aes_clk);
            chk("bp_vld", 128'(rsp_vld_o), 128'(1));
            chk("bp_id",  128'(rsp_id_o), 128'(0));
            chk("bp_ct",  rsp_cipher_text_o, exp);
            chk("bp_rdy", 128'(req_rdy_o), 128'(0));
            chk("bp_en",  128'(core_en_o), 128'(0));
        end
        edge1();
        rsp_rdy_i = 1'b1;
        wait_accept(who);
        chk("bp_next_who", 128'(who), 128'(1));
        edge1();
        req_vld_i[1] = 1'b0;
        wait_rsp();
        chk("bp_next_id", 128'(rsp_id_o), 128'(1));

`ifdef AES_ARB_TIMEOUT_EN
        // Watchdog: dead core, error response 11 cycles after LOAD
        edge1();
        stub_dead    = 1'b1;
        req_vld_i[3] = 1'b1;
        wait_accept(who);
        chk("to_who", 128'(who), 128'(3));
        edge1();
        req_vld_i[3] = 1'b0;
        @(negedge aes_clk);
        chk("to_load_en", 128'(core_en_o), 128'(1));
        for (int c = 1; c <= 10; c++) begin
            @(negedge aes_clk);
            chk($sformatf("to_wait%0d", c), 128'(rsp_vld_o), 128'(0));
        end
        @(negedge aes_clk);
        chk("to_vld", 128'(rsp_vld_o), 128'(1));
        chk("to_err", 128'(rsp_err_o), 128'(1));
        chk("to_ct",  rsp_cipher_text_o, 128'(0));
        chk("to_id",  128'(rsp_id_o), 128'(3));
        chk("to_en",  128'(core_en_o), 128'(0));
        edge1();
        stub_dead = 1'b0;
`endif

        repeat (2) @(negedge aes_clk);
        chk("onehot_grants", 128'(multi_gnt), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench time limit");
    end

endmodule
